// File: rtl/alkexec.sv
// alkexec: ALKCTL receiver with R/Q multiply/divide step datapath.
// Returns carry and Q[0] status to ALK and counts loop steps.
module alkexec (
  input  logic        qdclk_l,
  input  logic        reset_l,
  input  logic        alk_en_h,
  input  logic [6:0]  alkctl_h,
  input  logic        carry_invert_h,
  input  logic [31:0] b_h,
  input  logic [31:0] wbus_h,
  input  logic        ld_r_h,
  input  logic        ld_q_h,
  output logic [31:0] r_h,
  output logic [31:0] q_h,
  output logic        c32_h,
  output logic        q_sout_shr_h,
  output logic [4:0]  step_h,
  output logic        last_step_h
);

  logic [31:0] r;
  logic [31:0] q;
  logic [4:0]  step;

  logic [3:0]  code;
  logic        add;
  logic        is_mul;
  logic        is_byp;
  logic        is_div;
  logic        is_rem;
  logic [31:0] a;
  logic [31:0] bx;
  logic [32:0] sum;
  logic [31:0] t;
  logic        ovf;
  logic        sh;
  logic [31:0] src;
  logic        src_sh;
  logic        unused_ok;

  assign code      = alkctl_h[3:0];
  assign add       = alkctl_h[4];
  assign unused_ok = ^alkctl_h[6:5];

  assign is_mul = (code == 4'h9);
  assign is_byp = (code == 4'hB);
  assign is_div = (code == 4'hC);
  assign is_rem = (code == 4'hA);

  always_comb begin
    a   = is_div ? {r[30:0], q[31]} : r;
    bx  = add ? b_h : ~b_h;
    sum = {1'b0, a} + {1'b0, bx} + {32'd0, ~add};
    t   = sum[31:0];
    ovf = (a[31] == bx[31]) && (t[31] != a[31]);
    sh  = t[31] ^ ovf;
  end

  // Bypass shifts R itself; its sign is R[31] since no add overflows.
  assign src    = is_byp ? r : t;
  assign src_sh = is_byp ? r[31] : sh;

  always_ff @(posedge qdclk_l or negedge reset_l) begin
    if (!reset_l) begin
      r    <= '0;
      q    <= '0;
      step <= '0;
    end else if (ld_r_h || ld_q_h) begin
      if (ld_r_h) r <= wbus_h;
      if (ld_q_h) q <= wbus_h;
      step <= '0;
    end else if (alk_en_h) begin
      unique case (1'b1)
        is_mul, is_byp: begin
          r    <= {src_sh, src[31:1]};
          q    <= {src[0], q[31:1]};
          step <= step + 5'd1;
        end
        is_div: begin
          r    <= t;
          q    <= {q[30:0], c32_h};
          step <= step + 5'd1;
        end
        is_rem: r <= t;
        default: ;
      endcase
    end
  end

  assign r_h          = r;
  assign q_h          = q;
  assign c32_h        = sum[32] ^ carry_invert_h;
  assign q_sout_shr_h = q[0];
  assign step_h       = step;
  assign last_step_h  = &step;

endmodule

// File: tb/tb_alkexec.sv
// tb_alkexec: directed and randomized checks of alkexec
// against an arithmetic reference model.
module tb_alkexec;

  logic        qdclk_l = 1'b0;
  logic        reset_l = 1'b0;
  logic        alk_en_h = 1'b0;
  logic [6:0]  alkctl_h = '0;
  logic        carry_invert_h = 1'b0;
  logic [31:0] b_h = '0;
  logic [31:0] wbus_h = '0;
  logic        ld_r_h = 1'b0;
  logic        ld_q_h = 1'b0;
  logic [31:0] r_h;
  logic [31:0] q_h;
  logic        c32_h;
  logic        q_sout_shr_h;
  logic [4:0]  step_h;
  logic        last_step_h;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_r = '0;
  logic [31:0] m_q = '0;
  logic [4:0]  m_step = '0;

  alkexec dut (
    .qdclk_l(qdclk_l), .reset_l(reset_l), .alk_en_h(alk_en_h),
    .alkctl_h(alkctl_h), .carry_invert_h(carry_invert_h),
    .b_h(b_h), .wbus_h(wbus_h), .ld_r_h(ld_r_h), .ld_q_h(ld_q_h),
    .r_h(r_h), .q_h(q_h), .c32_h(c32_h), .q_sout_shr_h(q_sout_shr_h),
    .step_h(step_h), .last_step_h(last_step_h)
  );

  always #5 qdclk_l = ~qdclk_l;

  // Carry: ADD carries when the unsigned sum exceeds 32 bits,
  // SUB carries when there is no borrow (A >= B).
  function automatic logic exp_c32(input logic [31:0] r, input logic [31:0] q,
                                   input logic [31:0] b, input logic [6:0] op,
                                   input logic ci);
    logic [31:0] a;
    logic carry;
    a = (op[3:0] == 4'hC) ? {r[30:0], q[31]} : r;
    if (op[4]) carry = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
    else       carry = (a >= b);
    return carry ^ ci;
  endfunction

  task automatic model_tick();
    logic c;
    logic [31:0] a;
    longint sa, sb, s;
    logic [63:0] su;
    c = exp_c32(m_r, m_q, b_h, alkctl_h, carry_invert_h);
    sa = longint'($signed(m_r));
    sb = longint'($signed(b_h));
    if (ld_r_h || ld_q_h) begin
      if (ld_r_h) m_r = wbus_h;
      if (ld_q_h) m_q = wbus_h;
      m_step = 0;
    end else if (alk_en_h) begin
      case (alkctl_h[3:0])
        4'h9, 4'hB: begin
          if (alkctl_h[3:0] == 4'hB) s = sa;
          else s = alkctl_h[4] ? sa + sb : sa - sb;
          su = s;
          m_q = {su[0], m_q[31:1]};
          m_r = su[32:1];
          m_step = m_step + 1;
        end
        4'hC: begin
          a = {m_r[30:0], m_q[31]};
          m_r = alkctl_h[4] ? a + b_h : a - b_h;
          m_q = {m_q[30:0], c};
          m_step = m_step + 1;
        end
        4'hA: m_r = alkctl_h[4] ? m_r + b_h : m_r - b_h;
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic en, input logic [6:0] op, input logic ci,
                       input logic [31:0] b, input logic lr, input logic lq,
                       input logic [31:0] w);
    alk_en_h = en; alkctl_h = op; carry_invert_h = ci;
    b_h = b; ld_r_h = lr; ld_q_h = lq; wbus_h = w;
    #1;
  endtask

  task automatic tick();
    model_tick();
    @(posedge qdclk_l);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({r_h, q_h, step_h, last_step_h, q_sout_shr_h} !== '0) begin
      fails++; $display("FAIL reset_init got r=%h q=%h s=%0d", r_h, q_h, step_h);
    end
    @(posedge qdclk_l); #2;
    reset_l = 1'b1;
    drive(1'b0, 7'h00, 1'b0, 0, 1'b1, 1'b1, 32'hFFFF_FFFF); tick();
    drive(1'b1, 7'h5B, 1'b0, 0, 1'b0, 1'b0, 0); tick(); tick();
    #2;
    reset_l = 1'b0;
    #1;
    m_r = 0; m_q = 0; m_step = 0;
    tests++;
    if ({r_h, q_h, step_h, last_step_h, q_sout_shr_h} !== '0) begin
      fails++; $display("FAIL reset_async got r=%h q=%h s=%0d", r_h, q_h, step_h);
    end
    drive(1'b0, 7'h10, 1'b0, 0, 1'b0, 1'b0, 0);
    reset_l = 1'b1;
    tick(); tick();
    tests++;
    if ({r_h, q_h, step_h} !== '0) begin
      fails++; $display("FAIL reset_hold got r=%h q=%h s=%0d", r_h, q_h, step_h);
    end
    for (int ci = 0; ci < 2; ci++) begin
      drive(1'b0, 7'h10, ci[0], 0, 1'b0, 1'b0, 0);
      tests++;
      if (c32_h !== ci[0]) begin
        fails++; $display("FAIL reset_c32 got %b want %b", c32_h, ci[0]);
      end
    end
    drive(1'b1, 7'h59, 1'b0, 0, 1'b0, 1'b0, 0); tick();
    tests++;
    if (step_h !== 5'd1 || r_h !== 0) begin
      fails++; $display("FAIL reset_restart got s=%0d r=%h want 1,0", step_h, r_h);
    end
  endtask

  task automatic test_mul();
    drive(1'b0, 7'h00, 1'b0, 0, 1'b1, 1'b0, 0); tick();
    drive(1'b0, 7'h00, 1'b0, 0, 1'b0, 1'b1, 1); tick();
    drive(1'b1, 7'h59, 1'b0, 3, 1'b0, 1'b0, 0);
    tests++;
    if (c32_h !== 1'b0) begin
      fails++; $display("FAIL mul_c32 got %b want 0", c32_h);
    end
    tick();
    tests++;
    if (r_h !== 32'h1 || q_h !== 32'h8000_0000 || step_h !== 5'd1 ||
        q_sout_shr_h !== 1'b0) begin
      fails++; $display("FAIL mul_step got r=%h q=%h s=%0d", r_h, q_h, step_h);
    end
    drive(1'b0, 7'h00, 1'b0, 0, 1'b1, 1'b1, 32'h7FFF_FFFF); tick();
    drive(1'b0, 7'h00, 1'b0, 0, 1'b0, 1'b1, 0); tick();
    drive(1'b1, 7'h59, 1'b0, 1, 1'b0, 1'b0, 0); tick();
    tests++;
    if (r_h !== 32'h4000_0000 || q_h !== 32'h0) begin
      fails++; $display("FAIL mul_ovf got r=%h q=%h want 40000000,0", r_h, q_h);
    end
  endtask

  task automatic test_div();
    for (int ci = 0; ci < 2; ci++) begin
      drive(1'b0, 7'h00, 1'b0, 0, 1'b1, 1'b0, 0); tick();
      drive(1'b0, 7'h00, 1'b0, 0, 1'b0, 1'b1, 32'h8000_0000); tick();
      drive(1'b1, 7'h4C, ci[0], 1, 1'b0, 1'b0, 0);
      tests++;
      if (c32_h !== ~ci[0]) begin
        fails++; $display("FAIL div_c32 got %b want %b", c32_h, ~ci[0]);
      end
      tick();
      tests++;
      if (r_h !== 0 || q_h !== {31'd0, ~ci[0]}) begin
        fails++; $display("FAIL div_step got r=%h q=%h ci=%0d", r_h, q_h, ci);
      end
    end
  endtask

  task automatic test_rem();
    logic [4:0] s0;
    drive(1'b0, 7'h00, 1'b0, 0, 1'b1, 1'b0, 5); tick();
    drive(1'b1, 7'h59, 1'b0, 0, 1'b0, 1'b0, 0); tick();
    drive(1'b0, 7'h00, 1'b0, 0, 1'b1, 1'b0, 5); tick();
    drive(1'b1, 7'h59, 1'b0, 0, 1'b0, 1'b0, 0); tick(); tick();
    s0 = m_step;
    drive(1'b0, 7'h00, 1'b0, 0, 1'b1, 1'b0, 5);
    model_tick(); m_step = s0;
    @(posedge qdclk_l); #1;
    drive(1'b1, 7'h0A, 1'b0, 7, 1'b0, 1'b0, 0);
    tests++;
    if (c32_h !== 1'b0) begin
      fails++; $display("FAIL rem_c32 got %b want 0", c32_h);
    end
    tick();
    tests++;
    if (r_h !== 32'hFFFF_FFFE || step_h !== 5'd0) begin
      fails++; $display("FAIL rem_step got r=%h s=%0d", r_h, step_h);
    end
  endtask

  task automatic test_wrap_load();
    logic [31:0] r0;
    r0 = $urandom;
    drive(1'b0, 7'h00, 1'b0, 0, 1'b1, 1'b1, r0); tick();
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 7'h5B, 1'b0, $urandom, 1'b0, 1'b0, 0); tick();
    end
    tests++;
    if (last_step_h !== 1'b1 || step_h !== 5'd31) begin
      fails++; $display("FAIL wrap_last got s=%0d last=%b", step_h, last_step_h);
    end
    drive(1'b1, 7'h5B, 1'b0, 0, 1'b0, 1'b0, 0); tick();
    tests++;
    if (step_h !== 5'd0 || last_step_h !== 1'b0 || r_h !== m_r) begin
      fails++; $display("FAIL wrap_zero got s=%0d last=%b r=%h want r=%h",
                        step_h, last_step_h, r_h, m_r);
    end
    drive(1'b1, 7'h5B, 1'b0, 0, 1'b0, 1'b0, 0); tick();
    r0 = m_r;
    drive(1'b1, 7'h59, 1'b0, 5, 1'b0, 1'b1, 32'h1234); tick();
    tests++;
    if (q_h !== 32'h1234 || r_h !== r0 || step_h !== 5'd0) begin
      fails++; $display("FAIL load_prio got q=%h r=%h s=%0d want 1234,%h,0",
                        q_h, r_h, step_h, r0);
    end
  endtask

  task automatic test_random();
    logic [3:0] codes [5];
    logic [6:0] op;
    logic lr, lq;
    for (int i = 0; i < 400; i++) begin
      codes = '{4'h9, 4'hA, 4'hB, 4'hC, 4'($urandom)};
      op = {2'($urandom), 1'($urandom), codes[$urandom_range(4)]};
      lr = ($urandom_range(9) == 0);
      lq = ($urandom_range(9) == 0);
      drive($urandom_range(7) != 0, op, 1'($urandom),
            ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom,
            lr, lq, $urandom);
      tests++;
      if (c32_h !== exp_c32(m_r, m_q, b_h, alkctl_h, carry_invert_h) ||
          q_sout_shr_h !== m_q[0]) begin
        fails++; $display("FAIL rand_comb i=%0d got c=%b qs=%b op=%h",
                          i, c32_h, q_sout_shr_h, op);
      end
      tick();
      tests++;
      if (r_h !== m_r || q_h !== m_q || step_h !== m_step ||
          last_step_h !== (m_step == 5'd31)) begin
        fails++; $display("FAIL rand_state i=%0d got r=%h q=%h s=%0d want r=%h q=%h s=%0d",
                          i, r_h, q_h, step_h, m_r, m_q, m_step);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_rem();
    test_wrap_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alkexec.md
# alkexec

ALKCTL receiver and multiply/divide step datapath for the DPM. It sits at the far end of the ALKCTL bus, opposite the DC615 ALK control generator. It holds the 32-bit R (accumulator/remainder) and Q (multiplier/quotient) registers and executes one ALKCTL step per falling QDCLK edge. It returns the combinational status that ALK consumes to sequence its TOG/LOOP flags: `c32_h` and `q_sout_shr_h`. It also counts loop iterations so microcode and the bench can see when the 32-step loop ends.

## Interface
- No parameters; width is fixed at 32.
- `qdclk_l  in  1`: clock. All state updates on the rising edge of `qdclk_l`, which is the falling QDCLK edge.
- `reset_l  in  1`: asynchronous, active-low reset.
- `alk_en_h  in  1`: execute `alkctl_h` this cycle.
- `alkctl_h  in  7`: ALKCTL opcode from ALK.
  - Bit 4: 1 = ADD, 0 = SUB.
  - Bits 3:0: step select.
  - Bits 6:5: not decoded.
- `carry_invert_h  in  1`: from ALK; inverts the reported carry.
- `b_h  in  32`: ALU B operand (divisor / multiplicand).
- `wbus_h  in  32`: load data.
- `ld_r_h  in  1`: load R from `wbus_h`.
- `ld_q_h  in  1`: load Q from `wbus_h`.
- `r_h  out  32`: R register.
- `q_h  out  32`: Q register.
- `c32_h  out  1`: ALU carry out XOR `carry_invert_h`. Combinational; this is ALK's `c32_in_h`.
- `q_sout_shr_h  out  1`: Q[0]. Combinational from the register.
- `step_h  out  5`: step counter.
- `last_step_h  out  1`: high when `step_h == 31`.

## Operation
- Adder.
  - ADD: T = A + B.
  - SUB: T = A + ~B + 1.
  - In both cases carry = bit 32 of the 33-bit sum; SUB carry=1 means no borrow.
  - ovf = signed overflow of T.
- Shift-in bit: sh = T[31] ^ ovf, which is the true sign of the sum.
- Step codes (`alkctl_h[3:0]`), applied when `alk_en_h`=1 and neither load strobe is set:
  - 4'h9, MUL step: A=R.
    - R <= {sh, T[30:1]... }, i.e. T shifted right one place with sh entering bit 31.
    - Q <= {T[0], Q[31:1]}.
    - Step counter increments.
  - 4'hB, MUL bypass: T=R with no add, ovf=0.
    - R and Q shift exactly as for 4'h9.
    - Step counter increments.
    - `c32_h` reports the add/sub carry computed with A=R regardless.
  - 4'hC, DIV step: A = {R[30:0], Q[31]}.
    - R <= T.
    - Q <= {Q[30:0], `c32_h`}: the quotient bit shifts in.
    - Step counter increments.
  - 4'hA, REM fixup: A=R.
    - R <= T.
    - Q and counter unchanged.
  - Any other code: R, Q and counter hold. `c32_h` still reports A=R add/sub.
- Loads:
  - `ld_r_h` and `ld_q_h` take priority over any step.
  - The two loads may coincide.
  - Any load clears `step_h` to 0.
  - A register that is not being loaded holds during a load cycle; no step executes.
- Counter: 5 bits, wraps 31 -> 0 on the 32nd step. `last_step_h` is decoded from the registered value.
- `alk_en_h`=0 with no load: all state holds. Combinational outputs still track their inputs.

## Timing
- Reset (`reset_l`=0, asynchronous): R=0, Q=0, `step_h`=0, `last_step_h`=0. `q_sout_shr_h`=0 immediately.
- With R=0, B=0, op ADD: `c32_h` = `carry_invert_h`.
- Reset deasserted mid-loop: registers remain 0 and the counter restarts at 0 on the next step.
- One step per clock; results are visible the cycle after the edge.
- `c32_h` and `q_sout_shr_h` are zero-latency combinational functions of the current registers, `b_h`, `alkctl_h` and `carry_invert_h`, so ALK samples them on the same edge.
- No combinational path from `wbus_h`, `ld_*` or `alk_en_h` to any output.

## Test plan
1. Reset: assert `reset_l` low mid-step sequence -> all outputs 0 asynchronously. After release with no strobes, state holds at 0.
2. MUL step: R=0, Q=1, B=3, alkctl=7'h59 -> `c32_h`=0 before the edge; after the edge R=0x00000001, Q=0x80000000, `step_h`=1, `q_sout_shr_h`=0.
3. MUL overflow: R=0x7FFFFFFF, Q=0, B=1, 7'h59 -> R=0x40000000, Q=0.
4. DIV step: R=0, Q=0x80000000, B=1, 7'h4C, `carry_invert_h`=0 -> `c32_h`=1; after the edge R=0, Q=0x00000001.
   - Repeat with `carry_invert_h`=1 -> Q=0x00000000.
5. REM fixup: R=5, B=7, 7'h0A -> `c32_h`=0; after the edge R=0xFFFFFFFE, `step_h` unchanged.
6. Counter wrap and load priority: 31 steps of 7'h5B -> `last_step_h`=1; one more step -> `step_h`=0, `last_step_h`=0. Then `ld_q_h`=1 with op 7'h59 and `wbus_h`=0x1234 -> Q=0x1234, R unchanged, `step_h`=0.
